// File: rtl/adc_sample_capture.sv
// ADC sample capture: synchronises the divided SAMPLE_CLK, captures ADC_DATA on its rising
// edge, optionally averages (macro SAMPLE_AVG_EN), and queues words in a valid/ready FIFO.
module adc_sample_capture #(
   parameter int unsigned DATA_W   = 14,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned AVG_LOG2 = 2
) (
   input  logic              CLOCK_IN,
   input  logic              RESET_N,
   input  logic              SAMPLE_CLK,
   input  logic [DATA_W-1:0] ADC_DATA,
   input  logic              ENABLE,
   input  logic              CLEAR,
   output logic [DATA_W-1:0] OUT_DATA,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic              OVERFLOW,
   output logic [15:0]       SAMPLE_CNT
);

   localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned SCNT_W = 16;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
      $error("adc_sample_capture: DEPTH must be a power of two >= 2");
   end
   if (AVG_LOG2 > 16) begin : g_avg_chk
      $error("adc_sample_capture: AVG_LOG2 out of range");
   end

   // synchroniser and capture stage
   logic              s1_q, s1_d;
   logic              s2_q, s2_d;
   logic              s3_q, s3_d;
   logic              samp_rise_c;
   logic              cap_vld_q, cap_vld_d;
   logic [DATA_W-1:0] cap_data_q, cap_data_d;

   // word offered to the FIFO this cycle
   logic              push_c;
   logic [DATA_W-1:0] push_data_c;

   // FIFO and status
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              overflow_q, overflow_d;
   logic [SCNT_W-1:0] sample_cnt_q, sample_cnt_d;
   logic              pop_c;
   logic              full_c;
   logic              accept_c;

   always_comb begin
      s1_d        = SAMPLE_CLK;
      s2_d        = s1_q;
      s3_d        = s2_q;
      samp_rise_c = s2_q & ~s3_q;
      cap_vld_d   = samp_rise_c & ENABLE & ~CLEAR;
      cap_data_d  = cap_data_q;
      if (samp_rise_c && ENABLE) begin
         cap_data_d = ADC_DATA;
      end
   end

`ifdef SAMPLE_AVG_EN
   localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
   localparam int unsigned AC_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] sum_c;
   logic [AC_W-1:0]  acc_cnt_q, acc_cnt_d;
   logic             acc_last_c;

   // running sum; the last sample of a block is folded in and the block average pushed
   always_comb begin
      sum_c       = acc_q + ACC_W'(cap_data_q);
      acc_last_c  = (acc_cnt_q == AC_W'((1 << AVG_LOG2) - 1));
      acc_d       = acc_q;
      acc_cnt_d   = acc_cnt_q;
      push_c      = 1'b0;
      push_data_c = '0;
      if (CLEAR) begin
         acc_d     = '0;
         acc_cnt_d = '0;
      end else if (cap_vld_q) begin
         if (acc_last_c) begin
            push_c      = 1'b1;
            push_data_c = DATA_W'(sum_c >> AVG_LOG2);
            acc_d       = '0;
            acc_cnt_d   = '0;
         end else begin
            acc_d     = sum_c;
            acc_cnt_d = acc_cnt_q + AC_W'(1);
         end
      end
   end

   always_ff @(posedge CLOCK_IN or negedge RESET_N) begin
      if (!RESET_N) begin
         acc_q     <= '0;
         acc_cnt_q <= '0;
      end else begin
         acc_q     <= acc_d;
         acc_cnt_q <= acc_cnt_d;
      end
   end
`else
   always_comb begin
      push_c      = cap_vld_q;
      push_data_c = cap_data_q;
   end
`endif

   // FIFO: a full FIFO still accepts a push when the head pops in the same cycle
   always_comb begin
      pop_c        = out_valid_q & OUT_READY;
      full_c       = (count_q == CNT_W'(DEPTH));
      accept_c     = push_c & (~full_c | pop_c);
      mem_d        = mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      overflow_d   = overflow_q;
      sample_cnt_d = sample_cnt_q;
      if (CLEAR) begin
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         count_d      = '0;
         overflow_d   = 1'b0;
         sample_cnt_d = '0;
      end else begin
         if (accept_c) begin
            mem_d[wr_ptr_q] = push_data_c;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            sample_cnt_d    = sample_cnt_q + SCNT_W'(1);
         end else if (push_c) begin
            overflow_d = 1'b1;
         end
         if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(accept_c) - CNT_W'(pop_c);
      end
      out_valid_d = (count_d != '0);
      out_data_d  = out_valid_d ? mem_d[rd_ptr_d] : '0;
   end

   always_ff @(posedge CLOCK_IN or negedge RESET_N) begin
      if (!RESET_N) begin
         s1_q         <= 1'b0;
         s2_q         <= 1'b0;
         s3_q         <= 1'b0;
         cap_vld_q    <= 1'b0;
         cap_data_q   <= '0;
         mem_q        <= '{default: '0};
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         overflow_q   <= 1'b0;
         sample_cnt_q <= '0;
      end else begin
         s1_q         <= s1_d;
         s2_q         <= s2_d;
         s3_q         <= s3_d;
         cap_vld_q    <= cap_vld_d;
         cap_data_q   <= cap_data_d;
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         overflow_q   <= overflow_d;
         sample_cnt_q <= sample_cnt_d;
      end
   end

   assign OUT_DATA   = out_data_q;
   assign OUT_VALID  = out_valid_q;
   assign OVERFLOW   = overflow_q;
   assign SAMPLE_CNT = sample_cnt_q;

endmodule

// File: tb/tb_adc_sample_capture.sv
// Scoreboard bench for adc_sample_capture: sample-level reference model feeds an expected
// queue, an independent monitor checks every FIFO pop and the status outputs.
module tb_adc_sample_capture;

   localparam int DATA_W   = 14;
   localparam int DEPTH    = 4;
   localparam int AVG_LOG2 = 2;
`ifdef SAMPLE_AVG_EN
   localparam int SPW = 1 << AVG_LOG2;
`else
   localparam int SPW = 1;
`endif

   logic              CLOCK_IN;
   logic              RESET_N;
   logic              SAMPLE_CLK;
   logic [DATA_W-1:0] ADC_DATA;
   logic              ENABLE;
   logic              CLEAR;
   logic [DATA_W-1:0] OUT_DATA;
   logic              OUT_VALID;
   logic              OUT_READY;
   logic              OVERFLOW;
   logic [15:0]       SAMPLE_CNT;

   adc_sample_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AVG_LOG2(AVG_LOG2)) dut (
      .CLOCK_IN  (CLOCK_IN),
      .RESET_N   (RESET_N),
      .SAMPLE_CLK(SAMPLE_CLK),
      .ADC_DATA  (ADC_DATA),
      .ENABLE    (ENABLE),
      .CLEAR     (CLEAR),
      .OUT_DATA  (OUT_DATA),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .OVERFLOW  (OVERFLOW),
      .SAMPLE_CNT(SAMPLE_CNT)
   );

   initial CLOCK_IN = 1'b0;
   always #5 CLOCK_IN = ~CLOCK_IN;

   typedef struct {
      int                due;
      logic [DATA_W-1:0] data;
      logic              en;
   } ev_t;

   ev_t               ev_q[$];
   logic [DATA_W-1:0] exp_q[$];
   int                cyc = 0;
   int                mdl_cnt = 0;
   logic              mdl_ovf = 1'b0;
   logic [15:0]       mdl_scnt = '0;
   int                acc_sum = 0;
   int                acc_n = 0;
   int                vectors = 0;
   int                errors = 0;
   bit                rand_rdy = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic mdl_reset();
      ev_q.delete();
      exp_q.delete();
      mdl_cnt  = 0;
      mdl_ovf  = 1'b0;
      mdl_scnt = '0;
      acc_sum  = 0;
      acc_n    = 0;
   endtask

   // reference model: a SAMPLE_CLK rise driven after edge k becomes a FIFO word at edge k+4
   always @(posedge CLOCK_IN) begin : model
      bit                pop;
      bit                have;
      logic [DATA_W-1:0] w;
      ev_t               ev;
      cyc++;
      if (RESET_N) begin
         pop  = (mdl_cnt > 0) && OUT_READY;
         have = 1'b0;
         w    = '0;
         if (ev_q.size() > 0 && ev_q[0].due == cyc) begin
            ev = ev_q.pop_front();
            if (ev.en && !CLEAR) begin
               acc_sum += int'(ev.data);
               acc_n++;
               if (acc_n == SPW) begin
                  have    = 1'b1;
                  w       = DATA_W'(acc_sum / SPW);
                  acc_sum = 0;
                  acc_n   = 0;
               end
            end
         end
         if (CLEAR) begin
            exp_q.delete();
            mdl_cnt  = 0;
            mdl_ovf  = 1'b0;
            mdl_scnt = '0;
            acc_sum  = 0;
            acc_n    = 0;
         end else begin
            if (have) begin
               if (mdl_cnt == DEPTH && !pop) begin
                  mdl_ovf = 1'b1;
               end else begin
                  exp_q.push_back(w);
                  mdl_cnt++;
                  mdl_scnt++;
               end
            end
            if (pop) mdl_cnt--;
         end
      end
   end

   // monitor: status every cycle, data on every accepted word
   always @(negedge CLOCK_IN) begin : monitor
      logic [DATA_W-1:0] w;
      if (RESET_N) begin
         chk("out_valid", OUT_VALID, (mdl_cnt != 0));
         chk("overflow", OVERFLOW, mdl_ovf);
         chk("sample_cnt", SAMPLE_CNT, mdl_scnt);
         if (!OUT_VALID) chk("empty_data", OUT_DATA, 0);
         if (OUT_VALID && OUT_READY) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", OUT_DATA, 32'hFFFF_FFFF);
            end else begin
               w = exp_q.pop_front();
               chk("out_data", OUT_DATA, w);
            end
         end
      end
   end

   always @(posedge CLOCK_IN) begin
      if (rand_rdy) begin
         #1;
         OUT_READY = 1'($urandom_range(0, 1));
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge CLOCK_IN);
      #1;
   endtask

   task automatic rise(input logic [DATA_W-1:0] d, input logic en);
      ev_t ev;
      SAMPLE_CLK = 1'b1;
      ADC_DATA   = d;
      ENABLE     = en;
      ev.due     = cyc + 4;
      ev.data    = d;
      ev.en      = en;
      ev_q.push_back(ev);
   endtask

   task automatic send_sample(input logic [DATA_W-1:0] d, input logic en, input int hi, input int lo);
      rise(d, en);
      wait_cyc(hi);
      SAMPLE_CLK = 1'b0;
      wait_cyc(lo);
   endtask

   task automatic send_word(input logic [DATA_W-1:0] d);
      for (int i = 0; i < SPW; i++) send_sample(d, 1'b1, 2, 2);
   endtask

   task automatic clear_pulse();
      CLEAR = 1'b1;
      wait_cyc(1);
      CLEAR = 1'b0;
   endtask

   task automatic drain();
      OUT_READY = 1'b1;
      wait_cyc(DEPTH + 2);
      OUT_READY = 1'b0;
      chk("drained", OUT_VALID, 0);
   endtask

   initial begin
      RESET_N    = 1'b1;
      SAMPLE_CLK = 1'b0;
      ADC_DATA   = '0;
      ENABLE     = 1'b1;
      CLEAR      = 1'b0;
      OUT_READY  = 1'b0;
      #2 RESET_N = 1'b0;
      #1;
      chk("rst_valid", OUT_VALID, 0);
      chk("rst_data", OUT_DATA, 0);
      chk("rst_ovf", OVERFLOW, 0);
      chk("rst_cnt", SAMPLE_CNT, 0);
      wait_cyc(2);
      RESET_N = 1'b1;
      wait_cyc(2);

      // single sample latency
      for (int i = 0; i < SPW - 1; i++) send_sample(14'h1234, 1'b1, 2, 2);
      rise(14'h1234, 1'b1);
      wait_cyc(3);
      chk("lat_not_yet", OUT_VALID, 0);
      wait_cyc(1);
      chk("lat_valid", OUT_VALID, 1);
      chk("lat_data", OUT_DATA, 14'h1234);
      chk("lat_cnt", SAMPLE_CNT, 1);
      SAMPLE_CLK = 1'b0;
      wait_cyc(2);
      drain();

      // overflow on full FIFO
      clear_pulse();
      for (int k = 1; k <= 5; k++) send_word(DATA_W'(k));
      chk("ovf_set", OVERFLOW, 1);
      chk("ovf_cnt", SAMPLE_CNT, 4);
      drain();

      // full FIFO with pop on the push edge
      clear_pulse();
      chk("clr_ovf", OVERFLOW, 0);
      for (int k = 1; k <= 4; k++) send_word(DATA_W'(k));
      for (int i = 0; i < SPW - 1; i++) send_sample(14'd5, 1'b1, 2, 2);
      rise(14'd5, 1'b1);
      wait_cyc(3);
      OUT_READY = 1'b1;
      wait_cyc(1);
      OUT_READY  = 1'b0;
      SAMPLE_CLK = 1'b0;
      wait_cyc(2);
      chk("fullpop_ovf", OVERFLOW, 0);
      chk("fullpop_cnt", SAMPLE_CNT, 5);
      drain();

      // averaging block 10,20,30,41
      clear_pulse();
      send_sample(14'd10, 1'b1, 2, 2);
      send_sample(14'd20, 1'b1, 2, 2);
      send_sample(14'd30, 1'b1, 2, 2);
      send_sample(14'd41, 1'b1, 2, 2);
`ifdef SAMPLE_AVG_EN
      chk("avg_cnt", SAMPLE_CNT, 1);
      chk("avg_data", OUT_DATA, 25);
`else
      chk("avg_cnt", SAMPLE_CNT, 4);
      chk("avg_data", OUT_DATA, 10);
`endif
      drain();

      // CLEAR with queued words and a partial average
      clear_pulse();
      for (int k = 1; k <= 3; k++) send_word(DATA_W'(k));
      if (SPW > 1) begin
         send_sample(14'd7, 1'b1, 2, 2);
         send_sample(14'd7, 1'b1, 2, 2);
      end
      chk("pre_clr_cnt", SAMPLE_CNT, 3);
      clear_pulse();
      chk("clr_valid", OUT_VALID, 0);
      chk("clr_cnt", SAMPLE_CNT, 0);
      chk("clr_ovf2", OVERFLOW, 0);
      for (int i = 0; i < 4; i++) send_sample(14'd8, 1'b1, 2, 2);
      chk("post_clr_cnt", SAMPLE_CNT, 4 / SPW);
      chk("post_clr_data", OUT_DATA, 8);
      drain();

      // ENABLE low ignores edges
      clear_pulse();
      for (int i = 0; i < 3; i++) send_sample(DATA_W'(100 + i), 1'b0, 2, 2);
      chk("dis_cnt", SAMPLE_CNT, 0);
      chk("dis_valid", OUT_VALID, 0);
      ENABLE = 1'b1;

      // asynchronous reset with data queued
      send_word(14'h0AA);
      send_word(14'h155);
      chk("pre_rst_valid", OUT_VALID, 1);
      #2 RESET_N = 1'b0;
      #1;
      mdl_reset();
      chk("arst_valid", OUT_VALID, 0);
      chk("arst_data", OUT_DATA, 0);
      chk("arst_ovf", OVERFLOW, 0);
      chk("arst_cnt", SAMPLE_CNT, 0);
      #3 RESET_N = 1'b1;
      wait_cyc(2);

      // randomized traffic with random back-pressure
      rand_rdy = 1'b1;
      for (int i = 0; i < 150; i++) begin
         send_sample(DATA_W'($urandom), 1'($urandom_range(0, 3) != 0),
                     $urandom_range(2, 4), $urandom_range(2, 4));
      end
      rand_rdy = 1'b0;
      wait_cyc(1);
      OUT_READY = 1'b1;
      begin : final_drain
         int budget;
         budget = 200;
         while ((exp_q.size() != 0 || ev_q.size() != 0) && budget > 0) begin
            wait_cyc(1);
            budget--;
         end
         chk("drain_timeout", exp_q.size() + ev_q.size(), 0);
      end
      wait_cyc(2);
      chk("final_valid", OUT_VALID, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
